rx_block_assembler: RTL

- Receive-side stage directly downstream of block alignment.
- Collects the 8-bit symbols that block alignment qualifies into 128-bit blocks (16 symbols), tags each block with its sync-header type, and buffers completed blocks in a small FIFO.
- The FIFO is read by the descrambler/deframer through a valid/ready handshake.
- Detects mid-block resynchronisation and FIFO overflow.

---
 rtl/rx_block_assembler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_block_assembler.sv
// rx_block_assembler: gathers aligned 8-bit receive symbols into 128-bit
// blocks, tags each block with its sync-header type, and queues finished
// blocks in a small FIFO. A valid/ready port on the FIFO head feeds the
// descrambler.
// Optional build macro: RX_BLK_SKP_DROP_EN. When it is defined, SKP ordered
// sets are removed here and counted on skp_count instead of being queued.
module rx_block_assembler #(
  parameter int DATA_WIDTH        = 8,
  parameter int SYMBOLS_PER_BLOCK = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter int PTR_WIDTH         = 2
) (
  input  logic                                    rx_clk,
  input  logic                                    rx_rst,
  input  logic                                    soft_rst,
  input  logic                                    sym_valid,
  input  logic [DATA_WIDTH-1:0]                   sym_data,
  input  logic                                    sym_sob,
  input  logic                                    sym_type,
  output logic                                    blk_valid,
  input  logic                                    blk_ready,
  output logic [DATA_WIDTH*SYMBOLS_PER_BLOCK-1:0] blk_data,
  output logic                                    blk_type,
  output logic                                    err_partial,
  output logic                                    err_overflow,
`ifdef RX_BLK_SKP_DROP_EN
  output logic [7:0]                              skp_count,
`endif
  output logic [PTR_WIDTH:0]                      fifo_level
);

  localparam int BLK_W = DATA_WIDTH * SYMBOLS_PER_BLOCK;
  localparam int CNT_W = $clog2(SYMBOLS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYMBOLS_PER_BLOCK - 1);
  localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, FILL} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [BLK_W-1:0]     asmData_q;
  logic                 asmType_q;

  logic                 startBlk;
  logic                 storeSym;
  logic                 complete;
  logic                 partialEvt;

  logic [BLK_W-1:0]     memData_q [FIFO_DEPTH];
  logic                 memType_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_WIDTH:0]   level_q, level_d;
  logic [BLK_W-1:0]     headData_q, headData_d;
  logic                 headType_q, headType_d;
  logic                 errPartial_q, errOverflow_q;

  logic [BLK_W-1:0]     pushData;
  logic                 isSkp;
  logic                 pushReq;
  logic                 pushOk;
  logic                 pop;
  logic                 overflowEvt;

  // State register for the block-collection FSM
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_q <= IDLE;
    end else if (soft_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enter FILL on a start-of-block, leave after the last symbol
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sym_valid && sym_sob) state_d = FILL;
      FILL: if (sym_valid && !sym_sob && (count_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode: start, store, completion and early-restart strobes
  always_comb begin
    startBlk   = 1'b0;
    storeSym   = 1'b0;
    complete   = 1'b0;
    partialEvt = 1'b0;
    case (state_q)
      IDLE: begin
        if (sym_valid && sym_sob) startBlk = 1'b1;
      end
      FILL: begin
        if (sym_valid) begin
          if (sym_sob) begin
            startBlk   = 1'b1;
            partialEvt = 1'b1;
          end else begin
            storeSym = 1'b1;
            if (count_q == LAST_IDX) complete = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Assembly register, symbol index and latched block type
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      count_q   <= '0;
      asmData_q <= '0;
      asmType_q <= 1'b0;
    end else if (soft_rst) begin
      count_q   <= '0;
      asmData_q <= '0;
      asmType_q <= 1'b0;
    end else if (startBlk) begin
      asmData_q[DATA_WIDTH-1:0] <= sym_data;
      asmType_q                 <= sym_type;
      count_q                   <= CNT_W'(1);
    end else if (storeSym) begin
      asmData_q[count_q*DATA_WIDTH +: DATA_WIDTH] <= sym_data;
      count_q <= complete ? '0 : count_q + CNT_W'(1);
    end
  end

  // The final symbol bypasses the assembly register so the push lands on the completing cycle
  assign pushData = {sym_data, asmData_q[BLK_W-DATA_WIDTH-1:0]};

`ifdef RX_BLK_SKP_DROP_EN
  assign isSkp = asmType_q && (asmData_q[DATA_WIDTH-1:0] == DATA_WIDTH'(8'h99));
`else
  assign isSkp = 1'b0;
`endif

  // FIFO control: push/pop qualification, level and head look-ahead
  always_comb begin
    pushReq     = complete && !isSkp;
    pop         = (level_q != '0) && blk_ready;
    pushOk      = pushReq && ((level_q != FULL_LVL) || pop);
    overflowEvt = pushReq && (level_q == FULL_LVL) && !pop;
    wrPtr_d     = pushOk ? wrPtr_q + PTR_WIDTH'(1) : wrPtr_q;
    rdPtr_d     = pop ? rdPtr_q + PTR_WIDTH'(1) : rdPtr_q;
    level_d     = level_q;
    if (pushOk && !pop) level_d = level_q + (PTR_WIDTH+1)'(1);
    else if (!pushOk && pop) level_d = level_q - (PTR_WIDTH+1)'(1);
    headData_d  = '0;
    headType_d  = 1'b0;
    if (level_d != '0) begin
      if (pushOk && (wrPtr_q == rdPtr_d)) begin
        headData_d = pushData;
        headType_d = asmType_q;
      end else begin
        headData_d = memData_q[rdPtr_d];
        headType_d = memType_q[rdPtr_d];
      end
    end
  end

  // FIFO storage; stale entries are hidden by the level count so no reset is needed
  always_ff @(posedge rx_clk) begin
    if (pushOk) begin
      memData_q[wrPtr_q] <= pushData;
      memType_q[wrPtr_q] <= asmType_q;
    end
  end

  // FIFO pointers, level, registered head and sticky error flags
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      level_q       <= '0;
      headData_q    <= '0;
      headType_q    <= 1'b0;
      errPartial_q  <= 1'b0;
      errOverflow_q <= 1'b0;
    end else if (soft_rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      level_q       <= '0;
      headData_q    <= '0;
      headType_q    <= 1'b0;
      errPartial_q  <= 1'b0;
      errOverflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      headData_q <= headData_d;
      headType_q <= headType_d;
      if (partialEvt) errPartial_q <= 1'b1;
      if (overflowEvt) errOverflow_q <= 1'b1;
    end
  end

`ifdef RX_BLK_SKP_DROP_EN
  logic [7:0] skpCount_q;

  // Saturating count of SKP ordered sets removed from the stream
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      skpCount_q <= '0;
    end else if (soft_rst) begin
      skpCount_q <= '0;
    end else if (complete && isSkp && (skpCount_q != 8'hFF)) begin
      skpCount_q <= skpCount_q + 8'd1;
    end
  end

  assign skp_count = skpCount_q;
`endif

  assign blk_valid    = (level_q != '0);
  assign blk_data     = headData_q;
  assign blk_type     = headType_q;
  assign err_partial  = errPartial_q;
  assign err_overflow = errOverflow_q;
  assign fifo_level   = level_q;

endmodule
